// File: rtl/io_dispatch_registers.sv
// CPU register block that stages command words, queues them on a doorbell,
// offers queued commands to idle cores round-robin, and counts core
// completions to drive a level interrupt.

// Per-core completion detector: flags a busy 1->0 transition.
module io_dispatch_lane (
    input  logic gpu_clk,
    input  logic gpu_reset_n,
    input  logic busy,
    output logic done_edge
);
    logic busy_q;

    // Busy history starts at 0 so nothing counts right after reset release
    always_ff @(posedge gpu_clk or negedge gpu_reset_n) begin
        if (!gpu_reset_n) busy_q <= 1'b0;
        else              busy_q <= busy;
    end

    assign done_edge = busy_q & ~busy;
endmodule

module io_dispatch_registers #(
    parameter int CORE_COUNT        = 4,
    parameter int BYTES_PER_WORD    = 4,
    parameter int WORDS_PER_COMMAND = 3,
    parameter int COMMAND_DEPTH     = 8,
    localparam int WORD_BITS  = 8 * BYTES_PER_WORD,
    localparam int WORD_COUNT = 5 + WORDS_PER_COMMAND,
    localparam int AW         = $clog2(WORD_COUNT * BYTES_PER_WORD)
) (
    input  logic                                   gpu_clk,
    input  logic                                   gpu_reset_n,
    input  logic [AW-1:0]                          cpu_address,
    input  logic                                   cpu_rd_en,
    output logic [WORD_BITS-1:0]                   cpu_rd_data,
    input  logic [BYTES_PER_WORD-1:0]              cpu_wr_en,
    input  logic [WORD_BITS-1:0]                   cpu_wr_data,
    output logic [CORE_COUNT-1:0]                  core_cmd_valid,
    input  logic [CORE_COUNT-1:0]                  core_cmd_ready,
    output logic [WORDS_PER_COMMAND*WORD_BITS-1:0] core_cmd_data,
    input  logic [CORE_COUNT-1:0]                  core_busy,
    output logic                                   irq
);
    localparam int CMD_BITS   = WORDS_PER_COMMAND * WORD_BITS;
    localparam int PTR_W      = (COMMAND_DEPTH > 1) ? $clog2(COMMAND_DEPTH) : 1;
    localparam int CNT_W      = $clog2(COMMAND_DEPTH + 1);
    localparam int PW         = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
    localparam int IDX_ID     = 0;
    localparam int IDX_STATUS = 1;
    localparam int IDX_CTRL   = 2;
    localparam int IDX_DONE   = 3;
    localparam int IDX_STAGE  = 4;
    localparam int IDX_BELL   = 4 + WORDS_PER_COMMAND;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    logic [WORDS_PER_COMMAND-1:0][WORD_BITS-1:0] staging;
    logic [CMD_BITS-1:0]  fifo_mem [COMMAND_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 dispatch_enable, irq_enable, overflow;
    logic [WORD_BITS-1:0] done_count;
    logic [0:0]           state;
    logic [PW-1:0]        rr_ptr, target, pick;
    logic [PW:0]          scan;
    logic                 pick_found;
    logic [CORE_COUNT-1:0] done_edge;
    logic [4:0]           edge_count;
    logic [WORD_BITS:0]   done_sum;
    logic [31:0]          word_idx;
    logic                 wr_any, wr_ctrl, wr_done, push, push_ok, pop;
    logic [WORD_BITS-1:0] status, rd_mux;

    // Completion detectors, one per core
    for (genvar c = 0; c < CORE_COUNT; c++) begin : g_lane
        io_dispatch_lane u_lane (
            .gpu_clk     (gpu_clk),
            .gpu_reset_n (gpu_reset_n),
            .busy        (core_busy[c]),
            .done_edge   (done_edge[c])
        );
    end

    assign word_idx  = 32'(cpu_address) / 32'(BYTES_PER_WORD);
    assign wr_any    = |cpu_wr_en;
    assign wr_ctrl   = wr_any && (word_idx == 32'(IDX_CTRL));
    assign wr_done   = wr_any && (word_idx == 32'(IDX_DONE));
    assign push      = wr_any && (word_idx == 32'(IDX_BELL));
    assign fifo_full = (fifo_count == CNT_W'(COMMAND_DEPTH));
    assign push_ok   = push && !fifo_full;
    assign pop       = (state == ST_OFFER) && core_cmd_ready[target];

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(COMMAND_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Number of cores that finished this cycle
    always_comb begin
        edge_count = '0;
        for (int i = 0; i < CORE_COUNT; i++) edge_count = edge_count + 5'(done_edge[i]);
    end

    assign done_sum = {1'b0, done_count} + (WORD_BITS+1)'(edge_count);

    // First idle core at or after rr_ptr, wrapping
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        scan       = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            scan = {1'b0, rr_ptr} + (PW+1)'(i);
            if (scan >= (PW+1)'(CORE_COUNT)) scan = scan - (PW+1)'(CORE_COUNT);
            if (!pick_found && !core_busy[scan[PW-1:0]]) begin
                pick_found = 1'b1;
                pick       = scan[PW-1:0];
            end
        end
    end

    // Dispatch FSM: an offer, once made, stays up until the target accepts
    always_ff @(posedge gpu_clk or negedge gpu_reset_n) begin
        if (!gpu_reset_n) begin
            state  <= ST_IDLE;
            target <= '0;
            rr_ptr <= '0;
        end else if (state == ST_IDLE) begin
            if (dispatch_enable && (fifo_count != '0) && pick_found) begin
                state  <= ST_OFFER;
                target <= pick;
            end
        end else if (core_cmd_ready[target]) begin
            state  <= ST_IDLE;
            rr_ptr <= (target == PW'(CORE_COUNT - 1)) ? '0 : target + 1'b1;
        end
    end

    // Only the target sees valid; the async reset of state drops it at once
    always_comb begin
        core_cmd_valid = '0;
        if (state == ST_OFFER) core_cmd_valid[target] = 1'b1;
    end

    // Head is masked while empty so the bus reads 0 out of reset
    assign core_cmd_data = (fifo_count != '0) ? fifo_mem[rd_ptr] : '0;

    // Command storage; contents only matter while counted
    always_ff @(posedge gpu_clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= staging;
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge gpu_clk or negedge gpu_reset_n) begin
        if (!gpu_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_next(wr_ptr);
            if (pop)     rd_ptr <= ptr_next(rd_ptr);
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Control bits and the overflow flag; a new overflow wins over a clear
    always_ff @(posedge gpu_clk or negedge gpu_reset_n) begin
        if (!gpu_reset_n) begin
            dispatch_enable <= 1'b0;
            irq_enable      <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            if (wr_ctrl && cpu_wr_en[0]) begin
                dispatch_enable <= cpu_wr_data[0];
                irq_enable      <= cpu_wr_data[1];
            end
            if (push && fifo_full)                              overflow <= 1'b1;
            else if (wr_ctrl && cpu_wr_en[0] && cpu_wr_data[2]) overflow <= 1'b0;
        end
    end

    // Completion counter saturates; a write restarts it from this cycle's edges
    always_ff @(posedge gpu_clk or negedge gpu_reset_n) begin
        if (!gpu_reset_n) begin
            done_count <= '0;
            irq        <= 1'b0;
        end else begin
            if (wr_done)                done_count <= WORD_BITS'(edge_count);
            else if (done_sum[WORD_BITS]) done_count <= '1;
            else                        done_count <= done_sum[WORD_BITS-1:0];
            irq <= irq_enable && (done_count != '0);
        end
    end

    // Staging words with per-byte write enables; kept after a doorbell
    always_ff @(posedge gpu_clk or negedge gpu_reset_n) begin
        if (!gpu_reset_n) begin
            staging <= '0;
        end else begin
            for (int w = 0; w < WORDS_PER_COMMAND; w++)
                for (int b = 0; b < BYTES_PER_WORD; b++)
                    if (cpu_wr_en[b] && (word_idx == 32'(IDX_STAGE + w)))
                        staging[w][b*8 +: 8] <= cpu_wr_data[b*8 +: 8];
        end
    end

    // STATUS assembly
    always_comb begin
        status        = '0;
        status[0]     = (|core_busy) || (fifo_count != '0) || (state == ST_OFFER);
        status[1]     = fifo_full;
        status[2]     = overflow;
        status[15:8]  = 8'(fifo_count);
        status[31:16] = 16'(core_busy);
    end

    // Read mux; doorbell and out-of-range words read 0
    always_comb begin
        rd_mux = '0;
        if (word_idx == 32'(IDX_ID))     rd_mux = WORD_BITS'(CORE_COUNT);
        if (word_idx == 32'(IDX_STATUS)) rd_mux = status;
        if (word_idx == 32'(IDX_CTRL))   rd_mux = WORD_BITS'({irq_enable, dispatch_enable});
        if (word_idx == 32'(IDX_DONE))   rd_mux = done_count;
        for (int w = 0; w < WORDS_PER_COMMAND; w++)
            if (word_idx == 32'(IDX_STAGE + w)) rd_mux = staging[w];
    end

    // One-cycle registered read, held between strobes
    always_ff @(posedge gpu_clk or negedge gpu_reset_n) begin
        if (!gpu_reset_n)   cpu_rd_data <= '0;
        else if (cpu_rd_en) cpu_rd_data <= rd_mux;
    end
endmodule
